// File: rtl/diff_integrator.sv
// -----------------------------------------------------------------------------
// diff_integrator
//   Integrate-and-dump averager for the signed difference samples produced by
//   an upstream subtractor. N = 2^LOG2_N valid samples are summed into a
//   full-width accumulator. The sum is arithmetically shifted down by LOG2_N
//   and saturated to OUT_W bits. The result is then offered on a
//   valid/ready output register.
//
//   Optional feature macro: DIFF_INTEGRATOR_ROUND_EN
//     defined   -> round half up (adds 2^(LOG2_N-1) before the shift)
//     undefined -> floor (plain arithmetic shift)
//
// Ports
//   M100CLK      in   1      single clock, rising edge
//   reset        in   1      asynchronous active-low reset
//   enable       in   1      integration runs while high
//   in_valid     in   1      single-cycle strobe qualifying in_sum
//   in_sum       in   33     signed difference sample
//   clear_flags  in   1      clears sat_flag / overrun while high
//   out_ready    in   1      downstream accept
//   out_valid    out  1      out_data holds a result
//   out_data     out  OUT_W  signed saturated window average
//   sat_flag     out  1      sticky: a result was clamped
//   overrun      out  1      sticky: a result was dropped (output still full)
// -----------------------------------------------------------------------------
module diff_integrator #(
    parameter int LOG2_N = 4,
    parameter int OUT_W  = 16
) (
    input  logic                    M100CLK,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic signed [32:0]      in_sum,
    input  logic                    clear_flags,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    sat_flag,
    output logic                    overrun
);

    // Accumulator is wide enough that N full-scale samples never wrap.
    localparam int AW = 33 + LOG2_N;

    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1'b1);

    // Rounding and saturation work one bit wider than the accumulator, so
    // the rounding constant can never overflow the sum.
    localparam logic signed [AW:0] ROUND_ADD = {{AW{1'b0}}, 1'b1} << (LOG2_N - 1);
    localparam logic signed [AW:0] SAT_MAX   = {{(AW-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN   = {{(AW-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    // Clamp to the OUT_W signed range. The MSB of the return value flags
    // that clamping happened.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [AW:0] v);
        logic [OUT_W:0] res;
        if (v > SAT_MAX) begin
            res = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (v < SAT_MIN) begin
            res = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            res = {1'b0, v[OUT_W-1:0]};
        end
        return res;
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [AW-1:0]    r_acc;
    logic signed [AW-1:0]    w_acc_nxt;
    logic [LOG2_N-1:0]       r_count;
    logic [LOG2_N-1:0]       w_count_nxt;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_sat_flag;
    logic                    r_overrun;

    logic signed [AW-1:0]    w_sample;
    logic signed [AW:0]      w_rounded;
    logic signed [AW:0]      w_scaled;
    logic [OUT_W:0]          w_sat_res;
    logic                    w_dump;
    logic                    w_load;
    logic                    w_drop;

    assign w_sample = {{LOG2_N{in_sum[32]}}, in_sum};

    // Scale the completed window sum: optional rounding, floor shift, clamp.
    always_comb begin
`ifdef DIFF_INTEGRATOR_ROUND_EN
        w_rounded = {r_acc[AW-1], r_acc} + ROUND_ADD;
`else
        w_rounded = {r_acc[AW-1], r_acc};
`endif
        w_scaled  = w_rounded >>> LOG2_N;
        w_sat_res = sat_fn(w_scaled);
    end

    // The result is loaded only if the output slot is free or being
    // accepted on this edge. Otherwise it is dropped.
    always_comb begin
        w_dump = (r_state == ST_DUMP);
        w_load = w_dump && (!r_out_valid || out_ready);
        w_drop = w_dump && r_out_valid && !out_ready;
    end

    // Next-state and accumulator/counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                if (enable) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (!enable) begin
                    // Partial window is discarded.
                    w_state_nxt = ST_IDLE;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                end else if (in_valid) begin
                    w_acc_nxt   = r_acc + w_sample;
                    w_count_nxt = r_count + CNT_ONE;
                    if (r_count == CNT_LAST) begin
                        w_state_nxt = ST_DUMP;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DUMP: begin
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                if (enable) begin
                    w_state_nxt = ST_ACCUM;
                    // A sample arriving on the dump cycle opens the next window.
                    if (in_valid) begin
                        w_acc_nxt   = w_sample;
                        w_count_nxt = CNT_ONE;
                    end else begin
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_acc_nxt   = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    // State, accumulator and counter registers.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Output register with valid/ready handshake.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat_res[OUT_W-1:0];
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Sticky flags. A set on the same edge as clear_flags takes priority.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            r_sat_flag <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_dump && w_sat_res[OUT_W]) begin
                r_sat_flag <= 1'b1;
            end else if (clear_flags) begin
                r_sat_flag <= 1'b0;
            end else begin
                r_sat_flag <= r_sat_flag;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat_flag;
    assign overrun   = r_overrun;

endmodule
